conv3x3_prog: RTL and testbench
===============================

Name: conv3x3_prog

Overview:
- Parametrised successor to the fixed-kernel Gabor 3x3 convolution stage. It takes one 3x3 window per valid cycle from the line-buffer front end and produces one filtered pixel.
- Kernel coefficients are signed and run-time programmable through a shadow/active register bank. New coefficients take effect only at a frame boundary.
- The block has a 3-stage pipeline with rounding and a selectable output mode (clip or absolute value). It sits between the line buffer and the output pixel FIFO.

Parameters:
- PIX_W, 8, pixel width (unsigned) for each window tap and for the output.
- COEF_W, 10, coefficient width, signed two's complement.
- FRAC_BITS, 7, number of fractional bits in a coefficient. 1.0 = 2^FRAC_BITS. Legal range is 1..COEF_W-2.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_pixel_data  in  9*PIX_W  3x3 window. Tap k occupies [k*PIX_W +: PIX_W], k=0..8, row-major, k=4 is the centre.
- i_pixel_data_valid  in  1  window valid qualifier.
- i_sof  in  1  start of frame. Sampled only when i_pixel_data_valid=1.
- i_coef_wr  in  1  shadow-bank write strobe.
- i_coef_addr  in  4  shadow address. 0..8 = taps, 9 = mode register, 10..15 = ignored.
- i_coef_data  in  COEF_W  write data. For address 9 only bit 0 is used (0=clip, 1=abs).
- i_coef_commit  in  1  request to transfer the shadow bank to the active bank.
- o_convolved_data  out  PIX_W  filtered pixel.
- o_convolved_data_valid  out  1  output qualifier.
- o_coef_pending  out  1  a commit is waiting for the next frame start.

Behaviour:
- Reset (asynchronous assert, synchronous deassert at the system level):
  - o_convolved_data=0, o_convolved_data_valid=0, o_coef_pending=0.
  - All pipeline valid flags are cleared.
  - Active and shadow banks reset to the identity kernel: tap4 = 2^FRAC_BITS, all other taps 0, mode=clip.
- Shadow writes: when i_coef_wr=1 the write lands at the clock edge. Writes never disturb the active bank.
- Commit:
  - i_coef_commit=1 sets a pending flag, and the shadow contents are captured at that edge. A write and a commit in the same cycle include the written value.
  - A second commit while already pending recaptures the shadow bank.
  - The swap to the active bank occurs at the edge where pending=1 and i_pixel_data_valid=1 and i_sof=1. That SOF window and all later windows use the new bank. pending clears at the same edge.
  - A commit in the same cycle as an SOF does not apply to that SOF. It waits for the next one.
- Pipeline (no back-pressure; one window accepted per valid cycle):
  - S1: each tap is zero-extended to PIX_W+1 bits signed and multiplied by its active coefficient, giving PIX_W+COEF_W+1-bit products, which are registered. The active mode is captured alongside.
  - S2: the 9 products are summed into an accumulator of ACC_W = PIX_W+COEF_W+5 bits, signed, with no overflow possible. The sum is registered.
  - S3: round = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift, half rounds toward +inf).
    - Clip mode: result <0 gives 0; result >2^PIX_W-1 gives 2^PIX_W-1; otherwise the result itself.
    - Abs mode: |result|, saturated to 2^PIX_W-1.
    - The result is registered to o_convolved_data.
- Latency: output is valid exactly 3 cycles after the input valid cycle. Valid propagates through 3 registers.
- Bubbles and hold:
  - Invalid input cycles produce o_convolved_data_valid=0 three cycles later.
  - o_convolved_data holds its last value while valid=0.
- Mode and coefficients are pipelined with the data. A swap never corrupts windows already in flight.
- Reset mid-frame: in-flight results are discarded, pending clears, and the banks return to identity.

Test Plan:
- After reset, with identity kernel: window taps all 0 except tap4=137, valid for 1 cycle → o_convolved_data=137 with valid=1 exactly 3 cycles later, and valid=0 on the cycles before and after.
- Write taps 0..8 = 128, commit, then SOF window with all taps=255 → acc=293760, >>7 = 2295, clip → 255. o_coef_pending is 1 from the commit until the SOF edge, then 0.
- Write tap4 = -128 (0x380), commit, SOF, tap4=100 → clip mode outputs 0. Write addr9=1, commit, SOF → abs mode outputs 100.
- Rounding: kernel tap0=64 only, tap0=3 → 1.5 rounds to 2. tap0=1 → 0.5 rounds to 1. tap0=0 → 0.
- Commit timing: with kernel all-128 pending, stream 5 non-SOF windows → outputs still use the old kernel. The SOF window and all following windows use the new kernel. A commit asserted with SOF in the same cycle → the old kernel is used until the next SOF.
- Assert i_rst_n=0 for one cycle mid-stream with 2 windows in flight → valid drops immediately and no stale outputs appear after release. The next window is filtered by the identity kernel, and writes to addresses 10..15 have no effect.

Source files
------------

// File: rtl/conv3x3_prog.sv
// Programmable signed 3x3 convolution with a 3-stage pipeline and rounding.
// Coefficients go through a shadow bank and move into the active bank only on a start-of-frame window.
module conv3x3_prog #(
   parameter int PIX_W     = 8,
   parameter int COEF_W    = 10,
   parameter int FRAC_BITS = 7
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [9*PIX_W-1:0]   i_pixel_data,
   input  logic                 i_pixel_data_valid,
   input  logic                 i_sof,
   input  logic                 i_coef_wr,
   input  logic [3:0]           i_coef_addr,
   input  logic [COEF_W-1:0]    i_coef_data,
   input  logic                 i_coef_commit,
   output logic [PIX_W-1:0]     o_convolved_data,
   output logic                 o_convolved_data_valid,
   output logic                 o_coef_pending
);
   localparam int NTAP   = 9;
   localparam int CENTRE = 4;
   localparam int PROD_W = PIX_W + COEF_W + 1;
   localparam int ACC_W  = PIX_W + COEF_W + 5;
   localparam logic [COEF_W-1:0]       COEF_ONE = COEF_W'(32'd1 << FRAC_BITS);
   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(32'd1 << (FRAC_BITS - 1));
   localparam logic signed [ACC_W-1:0] PIX_MAX  = ACC_W'({PIX_W{1'b1}});

   logic [COEF_W-1:0]        shadow_q [NTAP];
   logic [COEF_W-1:0]        shadow_d [NTAP];
   logic                     shadow_mode_q;
   logic                     shadow_mode_d;
   logic [COEF_W-1:0]        cap_q [NTAP];
   logic                     cap_mode_q;
   logic [COEF_W-1:0]        act_q [NTAP];
   logic                     act_mode_q;
   logic                     pending_q;
   logic                     swap_s;
   logic [COEF_W-1:0]        coef_use_s [NTAP];
   logic                     mode_use_s;

   logic signed [PROD_W-1:0] prod_d [NTAP];
   logic signed [PROD_W-1:0] prod_q [NTAP];
   logic                     v1_q;
   logic                     mode1_q;
   logic signed [ACC_W-1:0]  acc_d;
   logic signed [ACC_W-1:0]  acc_q;
   logic                     v2_q;
   logic                     mode2_q;
   logic signed [ACC_W-1:0]  rnd_s;
   logic signed [ACC_W-1:0]  mag_s;
   logic [PIX_W-1:0]         pix_d;
   logic [PIX_W-1:0]         pix_q;
   logic                     v3_q;

   assign swap_s = pending_q & i_pixel_data_valid & i_sof;

   // Shadow next state; a commit in the same cycle captures this updated view
   always_comb begin
      shadow_mode_d = shadow_mode_q;
      for (int k = 0; k < NTAP; k++) begin
         shadow_d[k] = shadow_q[k];
      end
      if (i_coef_wr) begin
         for (int k = 0; k < NTAP; k++) begin
            if (i_coef_addr == 4'(k)) begin
               shadow_d[k] = i_coef_data;
            end else begin
               shadow_d[k] = shadow_q[k];
            end
         end
         if (i_coef_addr == 4'd9) begin
            shadow_mode_d = i_coef_data[0];
         end else begin
            shadow_mode_d = shadow_mode_q;
         end
      end else begin
         shadow_mode_d = shadow_mode_q;
      end
   end

   // The SOF window that triggers a swap already multiplies by the incoming bank
   always_comb begin
      mode_use_s = swap_s ? cap_mode_q : act_mode_q;
      for (int k = 0; k < NTAP; k++) begin
         coef_use_s[k] = swap_s ? cap_q[k] : act_q[k];
      end
   end

   // Coefficient banks and commit-pending flag
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < NTAP; k++) begin
            shadow_q[k] <= (k == CENTRE) ? COEF_ONE : '0;
            cap_q[k]    <= (k == CENTRE) ? COEF_ONE : '0;
            act_q[k]    <= (k == CENTRE) ? COEF_ONE : '0;
         end
         shadow_mode_q <= 1'b0;
         cap_mode_q    <= 1'b0;
         act_mode_q    <= 1'b0;
         pending_q     <= 1'b0;
      end else begin
         for (int k = 0; k < NTAP; k++) begin
            shadow_q[k] <= shadow_d[k];
         end
         shadow_mode_q <= shadow_mode_d;
         if (i_coef_commit) begin
            for (int k = 0; k < NTAP; k++) begin
               cap_q[k] <= shadow_d[k];
            end
            cap_mode_q <= shadow_mode_d;
         end
         if (swap_s) begin
            for (int k = 0; k < NTAP; k++) begin
               act_q[k] <= cap_q[k];
            end
            act_mode_q <= cap_mode_q;
         end
         pending_q <= i_coef_commit | (pending_q & ~swap_s);
      end
   end

   // S1 products: unsigned tap widened to signed, both operands extended to product width
   always_comb begin
      for (int k = 0; k < NTAP; k++) begin
         prod_d[k] = PROD_W'($signed({1'b0, i_pixel_data[k*PIX_W +: PIX_W]}))
                   * PROD_W'($signed(coef_use_s[k]));
      end
   end

   // S2 accumulation with sign extension of every product
   always_comb begin
      acc_d = '0;
      for (int k = 0; k < NTAP; k++) begin
         acc_d = acc_d + ACC_W'(prod_q[k]);
      end
   end

   // S3 rounding (half toward +inf) then clip or absolute-value saturation
   always_comb begin
      rnd_s = (acc_q + RND_HALF) >>> FRAC_BITS;
      mag_s = rnd_s[ACC_W-1] ? -rnd_s : rnd_s;
      pix_d = pix_q;
      if (mode2_q) begin
         pix_d = (mag_s > PIX_MAX) ? {PIX_W{1'b1}} : mag_s[PIX_W-1:0];
      end else if (rnd_s[ACC_W-1]) begin
         pix_d = '0;
      end else if (rnd_s > PIX_MAX) begin
         pix_d = {PIX_W{1'b1}};
      end else begin
         pix_d = rnd_s[PIX_W-1:0];
      end
   end

   // Pipeline registers; data stages only load on a valid beat so the output holds
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < NTAP; k++) begin
            prod_q[k] <= '0;
         end
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         mode1_q <= 1'b0;
         mode2_q <= 1'b0;
         acc_q   <= '0;
         pix_q   <= '0;
      end else begin
         v1_q <= i_pixel_data_valid;
         v2_q <= v1_q;
         v3_q <= v2_q;
         if (i_pixel_data_valid) begin
            for (int k = 0; k < NTAP; k++) begin
               prod_q[k] <= prod_d[k];
            end
            mode1_q <= mode_use_s;
         end
         if (v1_q) begin
            acc_q   <= acc_d;
            mode2_q <= mode1_q;
         end
         if (v2_q) begin
            pix_q <= pix_d;
         end
      end
   end

   assign o_convolved_data       = pix_q;
   assign o_convolved_data_valid = v3_q;
   assign o_coef_pending         = pending_q;

endmodule

// File: tb/tb_conv3x3_prog.sv
// Bench for conv3x3_prog: integer-arithmetic kernel/bank model with per-cycle compare,
// plus literal expectations for the directed windows.
`timescale 1ns/1ps
module tb_conv3x3_prog;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [71:0] i_pixel_data;
   logic        i_pixel_data_valid;
   logic        i_sof;
   logic        i_coef_wr;
   logic [3:0]  i_coef_addr;
   logic [9:0]  i_coef_data;
   logic        i_coef_commit;
   logic [7:0]  o_data;
   logic        o_valid;
   logic        o_pend;

   conv3x3_prog #(.PIX_W(8), .COEF_W(10), .FRAC_BITS(7)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_pixel_data(i_pixel_data), .i_pixel_data_valid(i_pixel_data_valid),
      .i_sof(i_sof), .i_coef_wr(i_coef_wr), .i_coef_addr(i_coef_addr),
      .i_coef_data(i_coef_data), .i_coef_commit(i_coef_commit),
      .o_convolved_data(o_data), .o_convolved_data_valid(o_valid),
      .o_coef_pending(o_pend)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // expected outputs indexed by the posedge count at which they are observed
   bit exp_v [2048];
   int exp_d [2048];
   bit exp_p [2048];

   // model banks (signed integer coefficients, 128 == 1.0)
   int m_sh [9];
   int m_cap [9];
   int m_act [9];
   bit m_shm, m_capm, m_actm, m_pend;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", 32'(o_valid), 32'(exp_v[cyc]));
         chk("out_data", 32'(o_data), exp_d[cyc]);
         chk("pending", 32'(o_pend), 32'(exp_p[cyc]));
      end
   end

   task automatic model_reset();
      for (int k = 0; k < 9; k++) begin
         m_sh[k]  = (k == 4) ? 128 : 0;
         m_cap[k] = (k == 4) ? 128 : 0;
         m_act[k] = (k == 4) ? 128 : 0;
      end
      m_shm = 1'b0; m_capm = 1'b0; m_actm = 1'b0; m_pend = 1'b0;
   endtask

   task automatic set_idle();
      i_pixel_data = '0; i_pixel_data_valid = 1'b0; i_sof = 1'b0;
      i_coef_wr = 1'b0; i_coef_addr = 4'd0; i_coef_data = 10'd0; i_coef_commit = 1'b0;
   endtask

   // one clock of stimulus; model advances across the same edge
   task automatic drive(input logic [71:0] win, input bit v, input bit sof, input bit wr,
                        input int addr, input int data, input bit commit, output int expd);
      int kern [9];
      bit md, swap;
      int acc, r, q, a, d;
      i_pixel_data = win; i_pixel_data_valid = v; i_sof = sof;
      i_coef_wr = wr; i_coef_addr = addr[3:0]; i_coef_data = data[9:0]; i_coef_commit = commit;
      swap = m_pend && v && sof;
      md = swap ? m_capm : m_actm;
      for (int k = 0; k < 9; k++) kern[k] = swap ? m_cap[k] : m_act[k];
      expd = 0;
      if (v) begin
         acc = 0;
         for (int k = 0; k < 9; k++) acc += int'(win[k*8 +: 8]) * kern[k];
         r = acc + 64;
         q = (r >= 0) ? r / 128 : -((-r + 127) / 128);
         if (md) begin
            a = (q < 0) ? -q : q;
            expd = (a > 255) ? 255 : a;
         end else begin
            expd = (q < 0) ? 0 : ((q > 255) ? 255 : q);
         end
         exp_v[cyc+3] = 1'b1;
         exp_d[cyc+3] = expd;
      end else begin
         exp_v[cyc+3] = 1'b0;
         exp_d[cyc+3] = exp_d[cyc+2];
      end
      if (swap) begin
         for (int k = 0; k < 9; k++) m_act[k] = m_cap[k];
         m_actm = m_capm;
      end
      if (wr) begin
         d = data & 1023;
         if (d >= 512) d -= 1024;
         if (addr < 9) m_sh[addr] = d;
         else if (addr == 9) m_shm = data[0];
      end
      if (commit) begin
         for (int k = 0; k < 9; k++) m_cap[k] = m_sh[k];
         m_capm = m_shm;
         m_pend = 1'b1;
      end else if (swap) begin
         m_pend = 1'b0;
      end
      exp_p[cyc+1] = m_pend;
      @(negedge clk); #1;
   endtask

   task automatic idle(input int n);
      int e;
      for (int i = 0; i < n; i++) drive('0, 0, 0, 0, 0, 0, 0, e);
   endtask

   task automatic wr(input int addr, input int data, input bit commit);
      int e;
      drive('0, 0, 0, 1, addr, data, commit, e);
   endtask

   task automatic cmt();
      int e;
      drive('0, 0, 0, 0, 0, 0, 1, e);
   endtask

   task automatic win(input logic [71:0] w, input bit sof, input int pin);
      int e;
      drive(w, 1, sof, 0, 0, 0, 0, e);
      if (pin >= 0) chk("model_pin", e, pin);
   endtask

   task automatic reset_mid();
      set_idle();
      rst_n = 1'b0;
      model_reset();
      for (int i = 1; i <= 3; i++) begin
         exp_v[cyc+i] = 1'b0;
         exp_d[cyc+i] = 0;
      end
      exp_p[cyc+1] = 1'b0;
      #1;
      chk("rst_valid_drop", 32'(o_valid), 0);
      chk("rst_data_clr", 32'(o_data), 0);
      chk("rst_pending_clr", 32'(o_pend), 0);
      @(negedge clk); #1;
      rst_n = 1'b1;
   endtask

   function automatic logic [71:0] w_all(input int v);
      logic [71:0] w;
      for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(v);
      return w;
   endfunction

   function automatic logic [71:0] w_one(input int k, input int v);
      logic [71:0] w;
      w = '0;
      w[k*8 +: 8] = 8'(v);
      return w;
   endfunction

   initial begin
      int e;
      set_idle();
      model_reset();
      @(negedge clk);
      chk("reset_valid", 32'(o_valid), 0);
      chk("reset_data", 32'(o_data), 0);
      chk("reset_pending", 32'(o_pend), 0);
      #1;
      rst_n = 1'b1;
      chk_en = 1'b1;
      idle(2);

      // identity kernel, single window, literal latency check
      win(w_one(4, 137), 0, 137);
      idle(2);
      chk("id_valid_lat3", 32'(o_valid), 1);
      chk("id_data", 32'(o_data), 137);
      idle(2);

      // all-128 kernel, last write shares the cycle with the commit
      for (int k = 0; k < 8; k++) wr(k, 128, 0);
      wr(8, 128, 1);
      drive(w_all(0), 0, 1, 0, 0, 0, 0, e);
      win(w_all(100), 0, 100);
      for (int i = 0; i < 4; i++) win(w_all(100), 0, 100);
      idle(1);
      win(w_all(255), 1, 255);
      win(w_all(10), 0, 90);
      idle(3);

      // negative centre tap: clip then abs
      for (int k = 0; k < 9; k++) wr(k, (k == 4) ? 'h380 : 0, 0);
      cmt();
      win(w_one(4, 100), 1, 0);
      idle(1);
      wr(9, 1, 1);
      win(w_one(4, 100) | w_one(0, 200), 1, 100);
      idle(3);

      // rounding with tap0 = 0.5; second commit recaptures over the first
      wr(9, 0, 0);
      wr(4, 0, 0);
      wr(0, 32, 1);
      wr(0, 64, 1);
      win(w_one(0, 3), 1, 2);
      win(w_one(0, 1), 0, 1);
      win(w_one(0, 0), 0, 0);
      idle(1);
      wr(0, 'h3C0, 0);
      wr(9, 1, 1);
      win(w_one(0, 3), 1, 1);
      win(w_one(0, 1), 0, 0);
      idle(2);

      // commit on the SOF cycle waits for the following SOF
      for (int k = 0; k < 9; k++) wr(k, 128, 0);
      wr(9, 0, 0);
      drive(w_all(100), 1, 1, 0, 0, 0, 1, e);
      chk("model_pin", e, 50);
      win(w_all(100), 0, 50);
      idle(1);
      win(w_all(100), 1, 255);
      idle(3);

      // most negative coefficients, abs mode saturation
      for (int k = 0; k < 9; k++) wr(k, 'h200, 0);
      wr(9, 1, 1);
      win(w_all(255), 1, 255);
      win(w_all(1), 0, 36);
      idle(3);

      // reset with windows in flight and a commit pending
      wr(4, 'h100, 1);
      for (int i = 0; i < 3; i++) win(w_all(1), 0, 36);
      reset_mid();
      idle(1);
      for (int a = 10; a < 16; a++) wr(a, 'h155, 0);
      cmt();
      win(w_one(4, 137) | w_one(0, 50), 1, 137);
      idle(2);
      chk("post_rst_valid", 32'(o_valid), 1);
      chk("post_rst_data", 32'(o_data), 137);
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
